// File: rtl/nolinear_pkg.sv
// Shared definitions for the nonlinear unit output stage: function modes,
// requant FSM states and the 8-bit saturation bounds.
package nolinear_pkg;

   // Function of the result vector; only softmax produces unsigned bytes.
   localparam logic [1:0] MODE_SOFTMAX = 2'b00;
   localparam logic [1:0] MODE_GELU    = 2'b01;
   localparam logic [1:0] MODE_SILU    = 2'b10;
   localparam logic [1:0] MODE_ROOT    = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // 8-bit saturation bounds for signed and unsigned outputs.
   localparam int S8_MAX = 127;
   localparam int S8_MIN = -128;
   localparam int U8_MAX = 255;
   localparam int U8_MIN = 0;

endpackage

// File: rtl/nolinear_requant_elem.sv
// Round-and-saturate of one fixed-point element down to a byte.
// Signed: round half up to an integer, clamp to [-128,127].
// Unsigned (softmax): keep 8 fractional bits' worth of magnitude, clamp to [0,255].
module nolinear_requant_elem
   import nolinear_pkg::*;
#(
   parameter int Bf              = 8,
   parameter int FIX_POINT_WIDTH = 16
) (
   input  logic [FIX_POINT_WIDTH-1:0] x_i,
   input  logic                       signed_i,
   output logic [7:0]                 byte_o,
   output logic                       sat_o
);

   // One extra bit so the rounding add on the largest positive input cannot wrap.
   localparam int XW    = FIX_POINT_WIDTH + 1;
   localparam int RU_SH = (Bf > 8) ? (Bf - 9) : 0;
   localparam logic signed [XW-1:0] RND_S = XW'(1 << (Bf - 1));
   localparam logic signed [XW-1:0] RND_U = (Bf > 8) ? XW'(1 << RU_SH) : XW'(0);

   logic signed [XW-1:0] xe;
   logic signed [XW-1:0] sum_s;
   logic signed [XW-1:0] sum_u;
   logic signed [XW-1:0] y_s;
   logic signed [XW-1:0] y_u;
   int                   ys;
   int                   yu;

   assign xe    = {x_i[FIX_POINT_WIDTH-1], x_i};
   assign sum_s = xe + RND_S;
   assign sum_u = xe + RND_U;
   assign y_s   = sum_s >>> Bf;
   assign y_u   = sum_u >>> (Bf - 8);

   // Clamp the rounded value to the byte range selected by signed_i.
   always_comb begin
      ys     = int'(y_s);
      yu     = int'(y_u);
      byte_o = '0;
      sat_o  = 1'b0;
      if (signed_i) begin
         if (ys > S8_MAX) begin
            ys    = S8_MAX;
            sat_o = 1'b1;
         end else if (ys < S8_MIN) begin
            ys    = S8_MIN;
            sat_o = 1'b1;
         end
         byte_o = ys[7:0];
      end else begin
         if (yu > U8_MAX) begin
            yu    = U8_MAX;
            sat_o = 1'b1;
         end else if (yu < U8_MIN) begin
            yu    = U8_MIN;
            sat_o = 1'b1;
         end
         byte_o = yu[7:0];
      end
   end

endmodule

// File: rtl/nolinear_requant.sv
// Output stage of the nonlinear unit: on finish, converts the whole fixed-point
// result vector to bytes, holds it, and streams it LANES bytes per beat over a
// valid/ready handshake. Finish pulses arriving while busy are dropped and
// flagged in the sticky drop_err.
// Optional: define NOLINEAR_REQUANT_SAT_CNT_EN to build the saturating
// sat_cnt counter; otherwise sat_cnt is tied to zero.
module nolinear_requant
   import nolinear_pkg::*;
#(
   parameter int Bf              = 8,
   parameter int FIX_POINT_WIDTH = 16,
   parameter int DATA_NUM        = 16,
   parameter int LANES           = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                finish,
   input  logic [1:0]                          mode,
   input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in_vec,
   output logic                                in_ready,
   output logic [LANES*8-1:0]                  out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_last,
   output logic                                drop_err,
   output logic [15:0]                         sat_cnt
);

   localparam int BEATS = DATA_NUM / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

   logic [DATA_NUM-1:0][7:0] conv_byte;
   logic [DATA_NUM-1:0]      conv_sat;
   logic [DATA_NUM-1:0][7:0] hold_q;
   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     drop_err_q;
   logic                     is_signed;
   logic                     capture;
   logic                     fire;
   logic                     last_beat;

   assign is_signed = (mode != MODE_SOFTMAX);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == SEND);
   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
   assign out_last  = out_valid && last_beat;
   assign capture   = finish && in_ready;
   assign fire      = out_valid && out_ready;
   assign drop_err  = drop_err_q;

   // Mode is consumed at capture time; the held bytes already carry its effect.
   for (genvar g = 0; g < DATA_NUM; g++) begin : g_elem
      nolinear_requant_elem #(
         .Bf              (Bf),
         .FIX_POINT_WIDTH (FIX_POINT_WIDTH)
      ) u_elem (
         .x_i      (in_vec[g*FIX_POINT_WIDTH +: FIX_POINT_WIDTH]),
         .signed_i (is_signed),
         .byte_o   (conv_byte[g]),
         .sat_o    (conv_sat[g])
      );
   end

   // State and beat counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: capture from IDLE, walk beats in SEND, return after the last handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (finish) begin
               state_d = SEND;
               cnt_d   = '0;
            end
         end
         SEND: begin
            if (fire) begin
               if (last_beat) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Holding register: loaded only when a finish is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
      end else if (capture) begin
         hold_q <= conv_byte;
      end
   end

   // Sticky drop flag: finish seen while a vector is still streaming.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_err_q <= 1'b0;
      end else if (finish && !in_ready) begin
         drop_err_q <= 1'b1;
      end
   end

   // Beat mux: lane j shows element cnt*LANES+j of the held vector.
   always_comb begin
      out_data = '0;
      for (int j = 0; j < LANES; j++) begin
         out_data[j*8 +: 8] = hold_q[IDX_W'(int'(cnt_q) * LANES + j)];
      end
   end

`ifdef NOLINEAR_REQUANT_SAT_CNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;
   logic [15:0] nsat;
   logic [16:0] sat_sum;

   // Add this vector's saturated-element count, sticking at all-ones.
   always_comb begin
      nsat = '0;
      for (int i = 0; i < DATA_NUM; i++) begin
         nsat = nsat + 16'(conv_sat[i]);
      end
      sat_sum   = {1'b0, sat_cnt_q} + {1'b0, nsat};
      sat_cnt_d = sat_cnt_q;
      if (capture) begin
         sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end

   // Saturation counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_cnt = sat_cnt_q;
`else
   logic unused_sat;
   assign unused_sat = ^conv_sat;
   assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_nolinear_requant.sv
// Scoreboard bench for nolinear_requant (Bf=8, DATA_NUM=16, LANES=4).
module tb_nolinear_requant;

   localparam int W  = 16;
   localparam int DN = 16;
   localparam int LN = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              finish;
   logic [1:0]        mode;
   logic [DN*W-1:0]   in_vec;
   logic              in_ready;
   logic [LN*8-1:0]   out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              drop_err;
   logic [15:0]       sat_cnt;

   beat_t sb[$];
   beat_t mon_e;
   int    n_chk  = 0;
   int    n_fail = 0;

`ifdef NOLINEAR_REQUANT_SAT_CNT_EN
   localparam logic [15:0] SAT_EXP1 = 16'd1;
`else
   localparam logic [15:0] SAT_EXP1 = 16'd0;
`endif

   nolinear_requant #(
      .Bf(8), .FIX_POINT_WIDTH(W), .DATA_NUM(DN), .LANES(LN)
   ) dut (
      .clk(clk), .rst(rst), .finish(finish), .mode(mode), .in_vec(in_vec),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .drop_err(drop_err),
      .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference conversion for Bf=8.
   function automatic logic [7:0] ref_conv(input logic [15:0] x, input logic sgn);
      int v;
      int y;
      v = int'($signed(x));
      if (sgn) begin
         y = (v + 128) >>> 8;
         if (y > 127) y = 127;
         else if (y < -128) y = -128;
      end else begin
         y = v;
         if (y > 255) y = 255;
         else if (y < 0) y = 0;
      end
      return y[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one finish pulse and queue the beats it should produce.
   task automatic send_vec(input logic [DN*W-1:0] v, input logic [1:0] m,
                           input logic lit_en, input logic [31:0] lit0);
      int    k;
      beat_t e;
      k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      chk("ready_before_send", in_ready, 1'b1);
      for (int b = 0; b < DN/LN; b++) begin
         e.data = '0;
         for (int j = 0; j < LN; j++)
            e.data[j*8 +: 8] = ref_conv(v[(b*LN+j)*W +: W], m != 2'b00);
         if (b == 0 && lit_en) e.data = lit0;
         e.last = (b == DN/LN - 1);
         sb.push_back(e);
      end
      finish = 1'b1;
      in_vec = v;
      mode   = m;
      tick();
      finish = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sb.size() != 0 || !in_ready) && k < 300) begin
         tick();
         k++;
      end
      chk("drain_in_time", k < 300, 1'b1);
   endtask

   function automatic logic [DN*W-1:0] rand_vec();
      logic [DN*W-1:0] v;
      for (int i = 0; i < DN; i++) v[i*W +: W] = 16'($urandom);
      return v;
   endfunction

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("extra_beat", out_valid, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("beat_data", out_data, mon_e.data);
            chk("beat_last", out_last, mon_e.last);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DN*W-1:0] v;
      logic [31:0]     snap;
      logic            snap_l;
      int              k;

      rst       = 1'b0;
      finish    = 1'b0;
      mode      = 2'b00;
      in_vec    = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_drop_err", drop_err, 1'b0);
      chk("rst_sat_cnt", sat_cnt, 16'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Signed rounding and saturation, mode 01.
      v = '0;
      v[0*W +: W] = 16'h0180;
      v[1*W +: W] = 16'hFE80;
      v[2*W +: W] = 16'h7FFF;
      v[3*W +: W] = 16'h8000;
      send_vec(v, 2'b01, 1'b1, 32'h807F_FF02);
      chk("sat_cnt_signed", sat_cnt, SAT_EXP1);
      wait_idle();

      // Softmax: unsigned clamp, last-beat marking and in_ready return.
      v = rand_vec();
      v[0*W +: W] = 16'h0100;
      v[1*W +: W] = 16'h0080;
      v[2*W +: W] = 16'hFF00;
      v[3*W +: W] = 16'h0000;
      send_vec(v, 2'b00, 1'b1, 32'h0000_80FF);
      k = 0;
      while (!(out_valid && out_last) && k < 50) begin
         tick();
         k++;
      end
      chk("last_seen", out_last, 1'b1);
      chk("in_ready_during_last", in_ready, 1'b0);
      tick();
      chk("in_ready_after_last", in_ready, 1'b1);
      chk("valid_after_last", out_valid, 1'b0);
      chk("four_beats", sb.size(), 0);

      // Backpressure mid-vector.
      send_vec(rand_vec(), 2'b10, 1'b0, 32'h0);
      tick();
      out_ready = 1'b0;
      snap   = out_data;
      snap_l = out_last;
      repeat (5) begin
         tick();
         chk("stall_data", out_data, snap);
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_last", out_last, snap_l);
      end
      out_ready = 1'b1;
      wait_idle();

      // Finish during SEND is dropped and flagged.
      send_vec(rand_vec(), 2'b01, 1'b0, 32'h0);
      tick();
      finish = 1'b1;
      in_vec = rand_vec();
      mode   = 2'b00;
      tick();
      finish = 1'b0;
      chk("drop_err_set", drop_err, 1'b1);
      wait_idle();
      repeat (8) tick();
      chk("no_second_vec", out_valid, 1'b0);

      // Asynchronous reset during beat 2.
      send_vec(rand_vec(), 2'b11, 1'b0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_drop_err", drop_err, 1'b0);
      chk("arst_out_last", out_last, 1'b0);
      chk("arst_sat_cnt", sat_cnt, 16'h0);
      sb.delete();
      tick();
      rst = 1'b1;
      tick();
      chk("no_partial_beat", out_valid, 1'b0);
      send_vec(rand_vec(), 2'b00, 1'b0, 32'h0);
      wait_idle();

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nolinear_requant.md
Name: nolinear_requant

Overview:
- Output stage for the nonlinear unit. The nonlinear top widens int8 inputs to signed Q(FIX_POINT_WIDTH-Bf).Bf; this block does the reverse conversion back to 8 bits.
- Captures the fixed-point result vector when the controller's finish pulses, rounds and saturates each element to 8 bits, and streams it out LANES elements per beat.
- Streaming uses a valid/ready handshake towards the downstream buffer.

Parameters:
- Bf, 8, fractional bits of the input fixed-point format; must be >= 8.
- FIX_POINT_WIDTH, 16, width of one fixed-point element.
- DATA_NUM, 16, number of elements per result vector.
- LANES, 4, elements emitted per output beat; DATA_NUM must be a multiple of LANES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- finish  input  1  one-cycle pulse: in_vec holds a valid result.
- mode  input  2  function of the result. 00 softmax gives unsigned output; 01/10/11 give signed output.
- in_vec  input  DATA_NUM*FIX_POINT_WIDTH  result vector; element i is at [i*FIX_POINT_WIDTH +: FIX_POINT_WIDTH].
- in_ready  output  1  high when the block can accept a finish pulse.
- out_data  output  LANES*8  lane j holds element beat*LANES+j.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  marks the final beat of a vector.
- drop_err  output  1  sticky flag; cleared only by reset.
- sat_cnt  output  16  saturation count (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State IDLE, beat counter 0.
- State IDLE, in_ready=1:
  - finish=1 latches mode and all DATA_NUM converted bytes into the holding register.
  - Go to SEND. out_valid rises the next cycle (latency 1).
- State SEND, in_ready=0:
  - out_data shows holding-register beat[cnt]. out_last = (cnt == DATA_NUM/LANES-1).
  - When out_valid && out_ready: cnt increments. On the last beat, cnt returns to 0 and the state returns to IDLE; in_ready is 1 the next cycle.
  - out_data, out_valid and out_last stay stable while out_ready=0.
  - A finish back-to-back with the last handshake is dropped, because in_ready is still 0 that cycle.
- A finish arriving while in_ready=0 is ignored and sets drop_err=1. The vector in flight is not disturbed.
- Conversion, signed modes (01/10/11), with x taken as signed and sign-extended to FIX_POINT_WIDTH+1 bits:
  - y = (x + 2^(Bf-1)) >>> Bf, an arithmetic shift, i.e. round half up.
  - Saturate y to [-128, 127] and output two's complement.
- Conversion, softmax (00):
  - y = (x + 2^(Bf-9)) >>> (Bf-8), with no rounding term when Bf=8.
  - Saturate y to [0, 255] and output unsigned; negative inputs give 0.
- Rounding is done in FIX_POINT_WIDTH+1 bits so that 0x7FFF does not wrap.
- Reset asserted mid-SEND: return to IDLE immediately and clear counter, flags and out_valid. No partial beat follows reset release.

Optional Feature:
- Macro NOLINEAR_REQUANT_SAT_CNT_EN.
- Defined: sat_cnt counts saturated elements, summed across all captured vectors. It holds at 0xFFFF, is cleared by reset, and increments in the capture cycle by the number of elements saturated in that vector.
- Undefined: sat_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package nolinear_pkg holds:
  - mode encodings MODE_SOFTMAX=2'b00, MODE_GELU=2'b01, MODE_SILU=2'b10, MODE_ROOT=2'b11;
  - the state encodings IDLE/SEND;
  - the saturation bounds.
- One sub-module, nolinear_requant_elem: combinational round-and-saturate for one element. Inputs are x and a signed/unsigned select; outputs are the byte and a sat flag. It is instantiated DATA_NUM times in a generate loop.

Test Plan (Bf=8, DATA_NUM=16, LANES=4):
- Signed rounding, mode 01: elements 0..3 = 0x0180, 0xFE80, 0x7FFF, 0x8000 → beat0 lanes = 0x02, 0xFF, 0x7F, 0x80; sat_cnt=1 when the macro is on.
- Softmax, mode 00: elements 0..2 = 0x0100, 0x0080, 0xFF00 → bytes 0xFF, 0x80, 0x00. Exactly 4 beats are emitted, out_last only on beat 3, and in_ready=1 one cycle after the final handshake.
- Backpressure: hold out_ready=0 for 5 cycles mid-vector → out_data/out_valid/out_last stay constant, and no beat is skipped or repeated.
- Drop: pulse finish again during SEND → drop_err=1, the original vector completes unchanged, and no second vector is emitted.
- Reset: assert rst=0 during beat 2 → out_valid=0 and in_ready=1 asynchronously. After release, a new finish streams beat 0 first.
